// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared encodings and constants for the reset stage sequencer.
// Holds the FSM state type, the SEQ_STATE width and the stage-count limit.
package rst_seq_pkg;

    // Width of SEQ_STATE and of the stage index / FAULT_STAGE.
    localparam int STATE_W    = 3;
    localparam int IDX_W      = 3;

    // Hard upper limit on the number of sequenced reset outputs.
    localparam int MAX_STAGES = 8;

    typedef enum logic [STATE_W-1:0] {
        S_WAIT_LOCK = 3'd0,
        S_RELEASE   = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_GAP       = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } seq_state_e;

    // Largest of three cycle counts; sizes the saturation point of a counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/rst_stage_sequencer_lock_filter.sv
// lock_stable_filter: 2-flop synchroniser for PLL_LOCKED plus a counter of
// consecutive synchronised-lock cycles.
// Ports: CLK, SYSTEM_RST_N (sync, active-low), PLL_LOCKED (async in),
//        lock_s (synchronised lock), lock_stable (lock held long enough).
module lock_stable_filter #(
    parameter int LOCK_STABLE_CYC = 1000,
    parameter int CNT_W           = 16
) (
    input  logic CLK,
    input  logic SYSTEM_RST_N,
    input  logic PLL_LOCKED,
    output logic lock_s,
    output logic lock_stable
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LOCK_STABLE_CYC - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;

    // The counter saturates at LAST so lock_stable stays high for as long
    // as the synchronised lock does; any low cycle restarts the count.
    always_ff @(posedge CLK) begin
        if (!SYSTEM_RST_N) begin
            sync_q <= '0;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[0], PLL_LOCKED};
            if (!sync_q[1]) begin
                cnt <= '0;
            end else if (cnt != LAST) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign lock_s      = sync_q[1];
    assign lock_stable = sync_q[1] && (cnt == LAST);

endmodule

// File: rtl/rst_stage_sequencer.sv
// rst_stage_sequencer: releases per-domain resets in ascending order once PLL
// lock is stable, waiting for each stage ACK plus a guard gap in between.
// Ports: CLK, SYSTEM_RST_N (sync, active-low), PLL_LOCKED (async),
//        STAGE_ACK[N] in; STAGE_RST_N[N], SEQ_DONE, SEQ_FAULT,
//        FAULT_STAGE[3], SEQ_STATE[3] out (all registered).
// Optional: define RST_SEQ_ACK_TIMEOUT_EN to enable the ACK timeout / FAULT
// state; otherwise WAIT_ACK waits forever and the fault outputs are 0.
module rst_stage_sequencer #(
    parameter int N_STAGES        = 4,
    parameter int LOCK_STABLE_CYC = 1000,
    parameter int STAGE_GAP_CYC   = 16,
    parameter int ACK_TIMEOUT_CYC = 65535,
    parameter int CNT_W           = 16
) (
    input  logic                CLK,
    input  logic                SYSTEM_RST_N,
    input  logic                PLL_LOCKED,
    input  logic [N_STAGES-1:0] STAGE_ACK,
    output logic [N_STAGES-1:0] STAGE_RST_N,
    output logic                SEQ_DONE,
    output logic                SEQ_FAULT,
    output logic [2:0]          FAULT_STAGE,
    output logic [2:0]          SEQ_STATE
);

    import rst_seq_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  =
        CNT_W'(max3(LOCK_STABLE_CYC, STAGE_GAP_CYC, ACK_TIMEOUT_CYC) - 1);
`ifdef RST_SEQ_ACK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT_CYC - 1);
`endif

    seq_state_e          state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic [IDX_W-1:0]    idx;
    logic [N_STAGES-1:0] rst_q;
    logic                done_q;
    logic [N_STAGES-1:0] sel;
    logic                ack_cur;
    logic                lock_s;
    logic                lock_stable;
    logic                lock_lost;

    lock_stable_filter #(
        .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
        .CNT_W           (CNT_W)
    ) u_lock (
        .CLK          (CLK),
        .SYSTEM_RST_N (SYSTEM_RST_N),
        .PLL_LOCKED   (PLL_LOCKED),
        .lock_s       (lock_s),
        .lock_stable  (lock_stable)
    );

    // One-hot select of the current stage; only its ACK is ever looked at,
    // which also avoids indexing with a wider-than-needed idx.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            sel[i] = (idx == IDX_W'(i));
        end
    end

    assign ack_cur = |(STAGE_ACK & sel);
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

    // FAULT and WAIT_LOCK are deliberately excluded: a fault is only cleared
    // by reset, and WAIT_LOCK already tracks lock through the filter.
    assign lock_lost = !lock_s &&
                       ((state == S_RELEASE) || (state == S_WAIT_ACK) ||
                        (state == S_GAP)     || (state == S_RUN));

`ifdef RST_SEQ_ACK_TIMEOUT_EN
    logic             fault_q;
    logic [IDX_W-1:0] fstage_q;
`endif

    always_ff @(posedge CLK) begin
        if (!SYSTEM_RST_N) begin
            state  <= S_WAIT_LOCK;
            cnt    <= '0;
            idx    <= '0;
            rst_q  <= '0;
            done_q <= 1'b0;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
            fault_q  <= 1'b0;
            fstage_q <= '0;
`endif
        end else if (lock_lost) begin
            // Lock loss beats any ACK seen on the same edge.
            state  <= S_WAIT_LOCK;
            cnt    <= '0;
            idx    <= '0;
            rst_q  <= '0;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                S_WAIT_LOCK: begin
                    cnt <= '0;
                    idx <= '0;
                    if (lock_stable) begin
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    rst_q <= rst_q | sel;
                    cnt   <= '0;
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (ack_cur) begin
                        if (idx == LAST_IDX) begin
                            state <= S_RUN;
                        end else begin
                            cnt   <= '0;
                            state <= S_GAP;
                        end
                    end
`ifdef RST_SEQ_ACK_TIMEOUT_EN
                    // ACK is tested first, so an ACK on the timeout
                    // cycle still wins.
                    else if (cnt == ACK_LAST) begin
                        rst_q    <= '0;
                        fault_q  <= 1'b1;
                        fstage_q <= idx;
                        state    <= S_FAULT;
                    end else begin
                        cnt <= cnt_inc;
                    end
`endif
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        idx   <= idx + IDX_W'(1);
                        state <= S_RELEASE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_RUN: begin
                    done_q <= 1'b1;
                end
                S_FAULT: begin
                    rst_q <= '0;
                end
                default: begin
                    state <= S_WAIT_LOCK;
                end
            endcase
        end
    end

    assign STAGE_RST_N = rst_q;
    assign SEQ_DONE    = done_q;
    assign SEQ_STATE   = state;

`ifdef RST_SEQ_ACK_TIMEOUT_EN
    assign SEQ_FAULT   = fault_q;
    assign FAULT_STAGE = fstage_q;
`else
    assign SEQ_FAULT   = 1'b0;
    assign FAULT_STAGE = 3'd0;
`endif

endmodule

// File: tb/tb_rst_stage_sequencer.sv
// Scoreboard bench for rst_stage_sequencer: stimulus pushes expected output
// changes (cycle + value); a negedge monitor pops and compares them.
module tb_rst_stage_sequencer;

    logic       clk = 1'b0;
    logic       system_rst_n;
    logic       pll_locked;
    logic [3:0] stage_ack;
    logic [3:0] stage_rst_n;
    logic       seq_done;
    logic       seq_fault;
    logic [2:0] fault_stage;
    logic [2:0] seq_state;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 1'b0;

    // val = {STAGE_RST_N, SEQ_DONE, SEQ_FAULT, FAULT_STAGE}
    typedef struct {
        int         cyc;
        logic [8:0] val;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        e;
    logic [8:0] prev;
    logic [8:0] cur;

    rst_stage_sequencer #(
        .N_STAGES        (4),
        .LOCK_STABLE_CYC (8),
        .STAGE_GAP_CYC   (4),
        .ACK_TIMEOUT_CYC (32),
        .CNT_W           (16)
    ) dut (
        .CLK          (clk),
        .SYSTEM_RST_N (system_rst_n),
        .PLL_LOCKED   (pll_locked),
        .STAGE_ACK    (stage_ack),
        .STAGE_RST_N  (stage_rst_n),
        .SEQ_DONE     (seq_done),
        .SEQ_FAULT    (seq_fault),
        .FAULT_STAGE  (fault_stage),
        .SEQ_STATE    (seq_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of the observed outputs must match the head of
    // the expectation queue, both in value and in the edge it happened on.
    always @(negedge clk) begin
        if (mon_en) begin
            cur = {stage_rst_n, seq_done, seq_fault, fault_stage};
            if (cur !== prev) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_change cyc=%0d got=%b",
                             cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.val !== cur) begin
                        miscompares++;
                        $display("FAIL event got cyc=%0d val=%b required cyc=%0d val=%b",
                                 cyc, cur, e.cyc, e.val);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic push(input int c, input logic [3:0] r, input logic d,
                        input logic f, input logic [2:0] fs);
        ev_t n;
        n.cyc = c;
        n.val = {r, d, f, fs};
        exp_q.push_back(n);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h required=%0h",
                     name, cyc, act, req);
        end
    endtask

    // Advance to 1 time unit after posedge number k.
    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise lock now (edge L = cyc); stage s rises at L+11+7*s, its ACK is
    // driven so it is sampled 2 edges after its release. ACK[2] is pulsed
    // while stage 1 is still waiting and must be ignored.
    task automatic run_seq(input int n_ack, output int r_last);
        int r;
        pll_locked = 1'b1;
        r = cyc + 11;
        for (int s = 0; s < n_ack; s++) begin
            push(r, 4'((1 << (s + 1)) - 1), 1'b0, 1'b0, 3'd0);
            if (s == 1) begin
                goto(r);
                stage_ack[2] = 1'b1;
                goto(r + 1);
                stage_ack[2] = 1'b0;
            end
            goto(r + 1);
            stage_ack[s] = 1'b1;
            if (s < n_ack - 1) r = r + 7;
        end
        if (n_ack == 4) push(r + 3, 4'hF, 1'b1, 1'b0, 3'd0);
        r_last = r;
    endtask

    // After a full run: drop ACKs in RUN (ignored), then drop lock.
    task automatic finish_run_and_drop(input int r);
        int d;
        goto(r + 6);
        stage_ack = 4'b0;
        goto(r + 10);
        chk("state_run", 32'(seq_state), 32'd4);
        chk("done_run", 32'(seq_done), 32'd1);
        d = cyc;
        pll_locked = 1'b0;
        push(d + 3, 4'h0, 1'b0, 1'b0, 3'd0);
        goto(d + 6);
        chk("state_after_loss", 32'(seq_state), 32'd0);
    endtask

    initial begin
        #500000;
        miscompares++;
        $display("FAIL watchdog cyc=%0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int r;
        int c;
        system_rst_n = 1'b0;
        pll_locked   = 1'b0;
        stage_ack    = 4'b0;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("reset_rst_n", 32'(stage_rst_n), 32'd0);
            chk("reset_done", 32'(seq_done), 32'd0);
            chk("reset_state", 32'(seq_state), 32'd0);
        end
        chk("reset_fault", 32'(seq_fault), 32'd0);
        chk("reset_fstage", 32'(fault_stage), 32'd0);

        prev   = {stage_rst_n, seq_done, seq_fault, fault_stage};
        mon_en = 1'b1;
        system_rst_n = 1'b1;

        // Lock with a 3-cycle glitch at t+5: count restarts from t+8.
        goto(6);
        t = cyc;
        pll_locked = 1'b1;
        goto(t + 5);
        pll_locked = 1'b0;
        goto(t + 8);
        chk("no_release_during_glitch", 32'(stage_rst_n), 32'd0);
        run_seq(4, r);
        finish_run_and_drop(r);

        // Lock loss in GAP after stage 1: r+3 drop, seen at r+6.
        run_seq(2, r);
        goto(r + 3);
        pll_locked = 1'b0;
        stage_ack  = 4'b0;
        push(r + 6, 4'h0, 1'b0, 1'b0, 3'd0);
        goto(r + 9);
        chk("state_gap_loss", 32'(seq_state), 32'd0);

        // Re-lock repeats the whole sequence from stage 0.
        run_seq(4, r);
        finish_run_and_drop(r);

`ifdef RST_SEQ_ACK_TIMEOUT_EN
        // ACK[2] withheld: fault 32 edges after STAGE_RST_N[2] rises.
        run_seq(2, r);
        push(r + 7, 4'b0111, 1'b0, 1'b0, 3'd0);
        push(r + 39, 4'h0, 1'b0, 1'b1, 3'd2);
        goto(r + 45);
        chk("state_fault", 32'(seq_state), 32'd5);
        pll_locked = 1'b0;
        goto(cyc + 10);
        chk("state_fault_hold", 32'(seq_state), 32'd5);
        c = cyc;
        system_rst_n = 1'b0;
        push(c + 1, 4'h0, 1'b0, 1'b0, 3'd0);
        goto(c + 2);
        chk("state_after_reset", 32'(seq_state), 32'd0);
        system_rst_n = 1'b1;
`else
        // ACK[1] withheld: sequencer simply waits in WAIT_ACK.
        run_seq(1, r);
        push(r + 7, 4'b0011, 1'b0, 1'b0, 3'd0);
        goto(r + 1007);
        chk("wait_state", 32'(seq_state), 32'd2);
        chk("wait_fault", 32'(seq_fault), 32'd0);
        chk("wait_rst_n", 32'(stage_rst_n), 32'b0011);
        c = cyc;
`endif

        goto(cyc + 5);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_events got=%0d required=0 next_cyc=%0d",
                     exp_q.size(), exp_q[0].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rst_stage_sequencer.md
Name: rst_stage_sequencer

Overview:
- Consumes the global power-on reset and releases per-domain resets in a fixed order: ADC/DAC datapath, DDS core, waveform memory, control/host interface.
- Waits for PLL lock to be stable first.
- Then deasserts each stage reset in turn, waiting for that stage's ready acknowledge plus a guard gap before moving to the next.
- Re-asserts every stage reset on loss of lock.

Parameters:
- N_STAGES, 4, number of sequenced reset outputs (1..8)
- LOCK_STABLE_CYC, 1000, consecutive synchronised-lock cycles required before the first release
- STAGE_GAP_CYC, 16, guard cycles between ACK of stage i and release of stage i+1 (>=1)
- ACK_TIMEOUT_CYC, 65535, maximum wait for a stage ACK (used only with the optional feature)
- CNT_W, 16, width of the shared cycle counter; must hold max(LOCK_STABLE_CYC, STAGE_GAP_CYC, ACK_TIMEOUT_CYC)

Ports:
- CLK  in  1  single system clock
- SYSTEM_RST_N  in  1  synchronous, active-low reset
- PLL_LOCKED  in  1  PLL lock, asynchronous to CLK
- STAGE_ACK  in  N_STAGES  per-stage ready, synchronous to CLK, level
- STAGE_RST_N  out  N_STAGES  per-stage active-low reset, registered
- SEQ_DONE  out  1  all stages released and acknowledged
- SEQ_FAULT  out  1  ACK timeout occurred (sticky)
- FAULT_STAGE  out  3  index of the stage that timed out
- SEQ_STATE  out  3  current FSM state, for debug

Behaviour:
- Reset (SYSTEM_RST_N=0 at a CLK edge):
  - STAGE_RST_N=all 0, SEQ_DONE=0, SEQ_FAULT=0, FAULT_STAGE=0.
  - Counter=0, stage index=0, sync flops=0, state=WAIT_LOCK.
  - Reset mid-sequence restarts from WAIT_LOCK.
- PLL_LOCKED passes through a 2-flop synchroniser; every FSM decision uses the synchronised value lock_s.
- States and encodings: WAIT_LOCK=0, RELEASE=1, WAIT_ACK=2, GAP=3, RUN=4, FAULT=5.
- WAIT_LOCK:
  - Counter increments while lock_s=1 and clears to 0 when lock_s=0.
  - When lock_s=1 and counter==LOCK_STABLE_CYC-1: clear counter, go to RELEASE.
- RELEASE:
  - Set STAGE_RST_N[idx]=1; it is visible on the next edge.
  - Clear counter, go to WAIT_ACK.
- WAIT_ACK:
  - Sample STAGE_ACK[idx] only. ACKs of other stages, and ACKs arriving before release, are ignored.
  - On ACK=1 and idx==N_STAGES-1: go to RUN.
  - On ACK=1 otherwise: clear counter, go to GAP.
- GAP:
  - Count STAGE_GAP_CYC cycles, then idx<=idx+1 and go to RELEASE.
  - Consequence: ACK sampled at edge e gives STAGE_RST_N[idx+1] high at e+STAGE_GAP_CYC+1.
- RUN: SEQ_DONE=1 registered; stage ACKs dropping in RUN are ignored.
- Release order is strictly ascending; stage i+1 is never released before ACK of stage i.
- Once released, a stage stays released until lock loss, fault, or reset.
- Lock loss (lock_s=0) in RELEASE, WAIT_ACK, GAP or RUN:
  - Next edge: STAGE_RST_N=all 0, SEQ_DONE=0, idx=0, counter=0, state=WAIT_LOCK.
  - Lock loss has priority over a same-cycle ACK.
- Lock loss in FAULT: ignored.
- Counter width overflow is not possible under the CNT_W rule; counters saturate rather than wrap.

Optional Feature:
- Macro: RST_SEQ_ACK_TIMEOUT_EN.
- Defined:
  - In WAIT_ACK the counter increments each cycle.
  - If counter==ACK_TIMEOUT_CYC-1 with no ACK: next edge STAGE_RST_N=all 0, SEQ_FAULT=1, FAULT_STAGE=idx, state=FAULT.
  - FAULT is exited only by SYSTEM_RST_N.
  - An ACK on the same cycle as the timeout wins, so no fault is raised.
- Undefined:
  - WAIT_ACK waits indefinitely.
  - SEQ_FAULT and FAULT_STAGE are tied to 0; FAULT state is unreachable; ACK_TIMEOUT_CYC is unused.

Decomposition:
- Package rst_seq_pkg: state encodings (3-bit constants), the SEQ_STATE width, and the maximum-stage constant 8.
- One sub-module, lock_stable_filter: 2-flop synchroniser plus consecutive-cycle counter.
  - Outputs lock_s and lock_stable.
  - Same CLK and SYSTEM_RST_N.

Test Plan (N_STAGES=4, LOCK_STABLE_CYC=8, STAGE_GAP_CYC=4, ACK_TIMEOUT_CYC=32):
- Power-up: hold SYSTEM_RST_N=0 for 5 cycles, PLL_LOCKED=0 -> all STAGE_RST_N=0, SEQ_DONE=0, SEQ_STATE=0 throughout.
- Lock latency: release reset, raise PLL_LOCKED at edge t -> STAGE_RST_N[0] rises at exactly t+11; a 3-cycle lock glitch at t+5 restarts the count.
- Ordered release: ACK each stage 2 cycles after its release -> STAGE_RST_N[1..3] each rise 5 cycles after the prior ACK edge; SEQ_DONE=1 one cycle after the ACK[3] edge; early ACK[2] before its release is ignored.
- Lock loss: drop PLL_LOCKED while in GAP after stage 1 -> all STAGE_RST_N=0 and SEQ_DONE=0 within 3 edges; re-lock repeats the full sequence from stage 0.
- Timeout (macro defined): withhold ACK[2] -> 32 cycles after STAGE_RST_N[2] rises, SEQ_FAULT=1, FAULT_STAGE=2, all STAGE_RST_N=0, state stays 5 until reset.
- Macro undefined: withhold ACK[1] for 1000 cycles -> SEQ_FAULT=0, state stays 2, STAGE_RST_N=4'b0011.
